// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, vector defaults and FSM states.
// Pure declarations; no timing or flow control of its own.
package cp0_ctrl_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] EX_ENTRY_DEF   = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RST_DEF = 32'h0040_0000;

    // ws_ex + excode + badvaddr + bd + pc
    localparam int WB_TO_CP0_WD = 1 + 5 + 32 + 1 + 32;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } cp0_state_e;

    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second cycle, TI latches on Count==Compare.
// Writes take effect on the next edge; a Compare write clears TI and beats a same-cycle match.
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            tick    <= 1'b0;
            count   <= 32'd0;
            compare <= 32'd0;
            ti      <= 1'b0;
        end else begin
            tick <= ~tick;
            if (count_we)
                count <= wdata;
            else if (tick)
                count <= count + 32'd1;

            if (compare_we) begin
                compare <= wdata;
                ti      <= 1'b0;
            end else if (count == compare) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_ctrl.sv
// CP0 register file and exception/ERET redirect sequencer; timer present only with CP0_TIMER_EN.
// Event in cycle N -> flush pulse in N+1; no backpressure, WB events are taken unconditionally.
module cp0_ctrl
    import cp0_ctrl_pkg::*;
#(
    parameter logic [31:0] EX_ENTRY   = EX_ENTRY_DEF,
    parameter logic [31:0] STATUS_RST = STATUS_RST_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_ex,
    input  logic [4:0]  ws_excode,
    input  logic [31:0] ws_badvaddr,
    input  logic        ws_bd,
    input  logic [31:0] ws_pc,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] mtc0_wdata,
    input  logic        eret_flush,
    input  logic [5:0]  ext_int_in,
    output logic [31:0] cp0_rdata,
    output logic        has_int,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic [31:0] cp0_epc
);

    logic [7:0]  st_im;
    logic        st_exl;
    logic        st_ie;
    logic        ca_bd;
    logic [7:0]  ca_ip;
    logic [4:0]  ca_excode;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;

    cp0_state_e  state;
    cp0_state_e  state_nxt;
    logic        flush_nxt;
    logic [31:0] flush_pc_nxt;

    logic        ex_take;
    logic        eret_take;
    logic        mtc0_take;
    logic [31:0] status_word;
    logic [31:0] cause_word;

    // While redirecting, the WB events belong to instructions being flushed.
    assign ex_take   = ws_ex && (state == ST_IDLE);
    assign eret_take = eret_flush && !ws_ex && (state == ST_IDLE);
    assign mtc0_take = mtc0_we && !ws_ex && !eret_flush;

`ifdef CP0_TIMER_EN
    logic count_we;
    logic compare_we;

    assign count_we   = mtc0_take && (cp0_addr == CP0_COUNT);
    assign compare_we = mtc0_take && (cp0_addr == CP0_COMPARE);

    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (count_we),
        .compare_we (compare_we),
        .wdata      (mtc0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
`else
    assign count   = 32'd0;
    assign compare = 32'd0;
    assign ti      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            st_im     <= STATUS_RST[15:8];
            st_exl    <= STATUS_RST[1];
            st_ie     <= STATUS_RST[0];
            ca_bd     <= 1'b0;
            ca_ip     <= 8'd0;
            ca_excode <= 5'd0;
            epc       <= 32'd0;
            badvaddr  <= 32'd0;
        end else begin
            ca_ip[7:2] <= {ti | ext_int_in[5], ext_int_in[4:0]};
            if (ex_take) begin
                // A nested exception keeps the original return point.
                if (!st_exl) begin
                    epc   <= ws_bd ? ws_pc - 32'd4 : ws_pc;
                    ca_bd <= ws_bd;
                end
                st_exl    <= 1'b1;
                ca_excode <= ws_excode;
                if (is_addr_exc(ws_excode))
                    badvaddr <= ws_badvaddr;
            end else if (eret_take) begin
                st_exl <= 1'b0;
            end else if (mtc0_take) begin
                case (cp0_addr)
                    CP0_STATUS: begin
                        st_im  <= mtc0_wdata[15:8];
                        st_exl <= mtc0_wdata[1];
                        st_ie  <= mtc0_wdata[0];
                    end
                    CP0_CAUSE: ca_ip[1:0] <= mtc0_wdata[9:8];
                    CP0_EPC:   epc        <= mtc0_wdata;
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            has_int <= 1'b0;
        else
            has_int <= (state == ST_IDLE) && !ws_ex && !eret_flush &&
                       st_ie && !st_exl && |(ca_ip & st_im);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            flush    <= 1'b0;
            flush_pc <= 32'd0;
        end else begin
            state    <= state_nxt;
            flush    <= flush_nxt;
            flush_pc <= flush_pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (ws_ex || eret_flush) state_nxt = ST_REDIRECT;
            ST_REDIRECT: state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        flush_nxt    = 1'b0;
        flush_pc_nxt = 32'd0;
        if (state == ST_IDLE) begin
            if (ws_ex) begin
                flush_nxt    = 1'b1;
                flush_pc_nxt = EX_ENTRY;
            end else if (eret_flush) begin
                flush_nxt    = 1'b1;
                flush_pc_nxt = epc;
            end
        end
    end

    assign status_word = {STATUS_RST[31:16], st_im, STATUS_RST[7:2], st_exl, st_ie};
    assign cause_word  = {ca_bd, ti, 14'd0, ca_ip, 1'b0, ca_excode, 2'b00};

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            CP0_BADVADDR: cp0_rdata = badvaddr;
            CP0_COUNT:    cp0_rdata = count;
            CP0_COMPARE:  cp0_rdata = compare;
            CP0_STATUS:   cp0_rdata = status_word;
            CP0_CAUSE:    cp0_rdata = cause_word;
            CP0_EPC:      cp0_rdata = epc;
            default:      cp0_rdata = 32'd0;
        endcase
    end

    assign cp0_epc = epc;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed and random stimulus for cp0_ctrl, checked against a word-level CP0 model.
module tb_cp0_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_ex;
    logic [4:0]  ws_excode;
    logic [31:0] ws_badvaddr;
    logic        ws_bd;
    logic [31:0] ws_pc;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] mtc0_wdata;
    logic        eret_flush;
    logic [5:0]  ext_int_in;
    logic [31:0] cp0_rdata;
    logic        has_int;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] cp0_epc;

    cp0_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .ws_ex       (ws_ex),
        .ws_excode   (ws_excode),
        .ws_badvaddr (ws_badvaddr),
        .ws_bd       (ws_bd),
        .ws_pc       (ws_pc),
        .mtc0_we     (mtc0_we),
        .cp0_addr    (cp0_addr),
        .mtc0_wdata  (mtc0_wdata),
        .eret_flush  (eret_flush),
        .ext_int_in  (ext_int_in),
        .cp0_rdata   (cp0_rdata),
        .has_int     (has_int),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .cp0_epc     (cp0_epc)
    );

    always #10 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Model state: whole architectural words; Cause bit 30 is composed from m_ti on read.
    logic [31:0] m_st, m_ca, m_epc, m_bva, m_fpc;
    logic        m_ti, m_has, m_fl, m_redir;
`ifdef CP0_TIMER_EN
    logic [31:0] m_cnt, m_cmp;
    logic        m_tick;
`endif

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_bva;
`ifdef CP0_TIMER_EN
            5'd9:  return m_cnt;
            5'd11: return m_cmp;
`endif
            5'd12: return m_st;
            5'd13: return m_ca | {1'b0, m_ti, 30'd0};
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_st = 32'h0040_0000; m_ca = 0; m_epc = 0; m_bva = 0; m_fpc = 0;
        m_ti = 0; m_has = 0; m_fl = 0; m_redir = 0;
`ifdef CP0_TIMER_EN
        m_cnt = 0; m_cmp = 0; m_tick = 0;
`endif
    endtask

    task automatic model_step();
        bit ex, er, mt, ti;
        logic [31:0] st, ca, epc, bva;
        if (reset) begin
            model_reset();
            return;
        end
        ex = ws_ex && !m_redir;
        er = eret_flush && !ws_ex && !m_redir;
        mt = mtc0_we && !ws_ex && !eret_flush;
        st = m_st; ca = m_ca; epc = m_epc; bva = m_bva; ti = m_ti;
`ifdef CP0_TIMER_EN
        if (m_cnt == m_cmp) ti = 1;
        if (mt && cp0_addr == 5'd11) begin
            m_cmp = mtc0_wdata;
            ti = 0;
        end
        if (mt && cp0_addr == 5'd9) m_cnt = mtc0_wdata;
        else                        m_cnt = m_cnt + (m_tick ? 32'd1 : 32'd0);
        m_tick = !m_tick;
`endif
        ca[15:10] = {m_ti | ext_int_in[5], ext_int_in[4:0]};
        if (ex) begin
            if (!m_st[1]) begin
                epc = ws_bd ? ws_pc - 32'd4 : ws_pc;
                ca[31] = ws_bd;
            end
            st[1] = 1'b1;
            ca[6:2] = ws_excode;
            if (ws_excode == 5'd4 || ws_excode == 5'd5) bva = ws_badvaddr;
        end else if (er) begin
            st[1] = 1'b0;
        end else if (mt) begin
            case (cp0_addr)
                5'd12: st = (m_st & ~32'h0000_FF03) | (mtc0_wdata & 32'h0000_FF03);
                5'd13: ca[9:8] = mtc0_wdata[9:8];
                5'd14: epc = mtc0_wdata;
                default: ;
            endcase
        end
        m_has = !m_redir && !ws_ex && !eret_flush && m_st[0] && !m_st[1] &&
                ((m_ca[15:8] & m_st[15:8]) != 8'd0);
        m_fl  = ex || er;
        m_fpc = ex ? 32'hBFC0_0380 : (er ? m_epc : 32'd0);
        m_redir = ex || er;
        m_st = st; m_ca = ca; m_epc = epc; m_bva = bva; m_ti = ti;
    endtask

    // Called just after a falling edge with inputs set; returns after the next falling edge.
    task automatic run_cycle();
        #1;
        chk("rdata", cp0_rdata, m_read(cp0_addr));
        model_step();
        @(negedge clk);
        chk("flush", 32'(flush), 32'(m_fl));
        if (m_fl) chk("flush_pc", flush_pc, m_fpc);
        chk("has_int", 32'(has_int), 32'(m_has));
        chk("epc", cp0_epc, m_epc);
    endtask

    task automatic idle();
        ws_ex = 0; mtc0_we = 0; eret_flush = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle(); mtc0_we = 1; cp0_addr = a; mtc0_wdata = d;
        run_cycle();
        idle();
    endtask

    task automatic raise_ex(input logic [4:0] code, input logic [31:0] pc,
                            input logic bd, input logic [31:0] bva);
        idle(); ws_ex = 1; ws_excode = code; ws_pc = pc; ws_bd = bd; ws_badvaddr = bva;
        run_cycle();
        idle();
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        idle(); cp0_addr = a;
        #1 v = cp0_rdata;
        run_cycle();
    endtask

    logic [31:0] v;
    logic [4:0]  codes[7] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
    logic [4:0]  addrs[7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};

    initial begin
        reset = 1; idle(); ws_excode = 0; ws_pc = 0; ws_bd = 0; ws_badvaddr = 0;
        cp0_addr = 0; mtc0_wdata = 0; ext_int_in = 0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 0;
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_has_int", 32'(has_int), 32'd0);
        rd(5'd12, v); chk("rst_status", v, 32'h0040_0000);
        rd(5'd13, v); chk("rst_cause_exc", {v[31], v[6:2]}, 32'd0);
        rd(5'd14, v); chk("rst_epc", v, 32'd0);

        raise_ex(5'd4, 32'hBFC0_0100, 1'b0, 32'h0000_0003);
        chk("ex_flush", 32'(flush), 32'd1);
        chk("ex_flush_pc", flush_pc, 32'hBFC0_0380);
        chk("ex_epc", cp0_epc, 32'hBFC0_0100);
        rd(5'd8, v); chk("ex_badvaddr", v, 32'd3);
        chk("ex_flush_drop", 32'(flush), 32'd0);
        rd(5'd13, v); chk("ex_excode", 32'(v[6:2]), 32'd4);
        rd(5'd12, v); chk("ex_status", v, 32'h0040_0002);

        mtc0(5'd12, 32'd0);
        raise_ex(5'd12, 32'h8000_0010, 1'b1, 32'h1234_5678);
        chk("bd_epc", cp0_epc, 32'h8000_000C);
        rd(5'd13, v); chk("bd_bit", 32'(v[31]), 32'd1);
        raise_ex(5'd0, 32'h8000_0100, 1'b0, 32'h0);
        chk("nested_epc", cp0_epc, 32'h8000_000C);
        mtc0(5'd14, 32'h8000_0040);
        rd(5'd8, v); chk("nested_badvaddr", v, 32'd3);

        eret_flush = 1; run_cycle(); idle();
        chk("eret_flush", 32'(flush), 32'd1);
        chk("eret_flush_pc", flush_pc, 32'h8000_0040);
        rd(5'd12, v); chk("eret_exl", 32'(v[1]), 32'd0);
        ws_ex = 1; eret_flush = 1; ws_excode = 5'd8; ws_pc = 32'h100; ws_bd = 0;
        run_cycle(); idle();
        chk("ex_over_eret", flush_pc, 32'hBFC0_0380);
        rd(5'd14, v); chk("ex_over_eret_epc", v, 32'h100);

        mtc0(5'd12, 32'h0000_0101);
        mtc0(5'd13, 32'h0000_0100);
        run_cycle(); chk("sw_int", 32'(has_int), 32'd1);
        mtc0(5'd13, 32'd0);
        mtc0(5'd12, 32'h0000_0001);
        ext_int_in = 6'h01;
        run_cycle(); run_cycle(); chk("int_im0", 32'(has_int), 32'd0);
        mtc0(5'd12, 32'h0000_0401);
        run_cycle(); chk("int_ext", 32'(has_int), 32'd1);
        mtc0(5'd12, 32'h0000_0403);
        run_cycle(); chk("int_exl", 32'(has_int), 32'd0);
        ext_int_in = 0;
        mtc0(5'd12, 32'd0);

`ifdef CP0_TIMER_EN
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        repeat (12) run_cycle();
        rd(5'd13, v); chk("ti_set", 32'(v[30]), 32'd1);
        mtc0(5'd12, 32'h0000_8001);
        run_cycle(); chk("ti_int", 32'(has_int), 32'd1);
        mtc0(5'd11, 32'hFFFF_0000);
        rd(5'd13, v); chk("ti_clr", 32'(v[30]), 32'd0);
        mtc0(5'd12, 32'd0);
`else
        mtc0(5'd9, 32'h1234_5678);
        rd(5'd9, v); chk("no_timer_count", v, 32'd0);
        mtc0(5'd11, 32'h0000_0005);
        rd(5'd11, v); chk("no_timer_compare", v, 32'd0);
`endif

        raise_ex(5'd10, 32'h0000_0200, 1'b0, 32'h0);
        reset = 1; run_cycle(); reset = 0;
        chk("rst_in_redirect", 32'(flush), 32'd0);

        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 99) == 0);
            ws_ex       = ($urandom_range(0, 7) == 0);
            ws_excode   = codes[$urandom_range(0, 6)];
            ws_pc       = $urandom;
            ws_bd       = 1'($urandom_range(0, 1));
            ws_badvaddr = $urandom;
            eret_flush  = ($urandom_range(0, 7) == 0);
            mtc0_we     = ($urandom_range(0, 2) == 0);
            cp0_addr    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                                       : addrs[$urandom_range(0, 6)];
            mtc0_wdata  = $urandom;
            ext_int_in  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            run_cycle();
        end
        reset = 0; idle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
